// File: rtl/regfile_sb.sv
// Purpose : multi-port integer register file with per-register busy scoreboard
//           and optional same-cycle write-to-read forwarding; register 0 is hard zero.
// Latency : reads combinational; write->array read 1 cycle, write->bypassed read 0
//           cycles, claim->rd_ready low 1 cycle.
// Backpressure: none; every write and claim is accepted each cycle, and operand
//           readiness is reported on rd_ready instead of stalling.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   rs/rs_valid         per-read-port address and enable
//   rd/rd_ready         per-read-port data and "operand not pending"
//   rw/we/wval          per-write-port address, enable, data (highest port wins)
//   claim/claim_reg     issue-side destination claim (sets busy)
//   busy                scoreboard bits, bit 0 always 0
module regfile_sb #(
  parameter int Width    = 32,
  parameter int NumRegs  = 32,
  parameter int NumRead  = 2,
  parameter int NumWrite = 1,
  parameter int Bypass   = 1,
  localparam int AddrW   = $clog2(NumRegs)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NumRead-1:0][AddrW-1:0]       rs,
  input  logic [NumRead-1:0]                  rs_valid,
  output logic [NumRead-1:0][Width-1:0]       rd,
  output logic [NumRead-1:0]                  rd_ready,
  input  logic [NumWrite-1:0][AddrW-1:0]      rw,
  input  logic [NumWrite-1:0]                 we,
  input  logic [NumWrite-1:0][Width-1:0]      wval,
  input  logic                                claim,
  input  logic [AddrW-1:0]                    claim_reg,
  output logic [NumRegs-1:0]                  busy
);

  // When NumRegs fills the address space every nonzero address is real.
  localparam bit Pow2 = (NumRegs == (1 << AddrW));

  // True for an address that names a real, writable register (not 0, not past the end).
  function automatic logic addr_ok(input logic [AddrW-1:0] a);
    return (a != '0) && (Pow2 || (32'(a) < 32'(NumRegs)));
  endfunction

  logic [NumRegs-1:0][Width-1:0] regs_q, regs_d;
  logic [NumRegs-1:0]            busy_q, busy_d;

  // Next state: writes first (ascending port order so the highest port wins),
  // then the claim, so a claim on the retiring register leaves it busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NumWrite; i++) begin
      if (we[i] && addr_ok(rw[i])) begin
        regs_d[rw[i]] = wval[i];
        busy_d[rw[i]] = 1'b0;
      end
    end
    if (claim && addr_ok(claim_reg)) begin
      busy_d[claim_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports. Disabled, zero and out-of-range reads return 0 and are always ready.
  // A forwarded write supplies the value the pending producer is delivering now,
  // so it is ready even though the busy bit is still set this cycle.
  always_comb begin
    for (int j = 0; j < NumRead; j++) begin
      rd[j]       = '0;
      rd_ready[j] = 1'b1;
      if (rs_valid[j] && addr_ok(rs[j])) begin
        rd[j]       = regs_q[rs[j]];
        rd_ready[j] = ~busy_q[rs[j]];
        if (Bypass != 0) begin
          for (int i = 0; i < NumWrite; i++) begin
            if (we[i] && (rw[i] == rs[j])) begin
              rd[j]       = wval[i];
              rd_ready[j] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and random checks of regfile_sb: a default instance (1 write port,
// forwarding on) and a narrow instance (6 regs, 2 write ports, no forwarding).
module tb_regfile_sb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: defaults (Width 32, 32 regs, 2 read, 1 write, Bypass 1)
  logic [1:0][4:0]  rs;
  logic [1:0]       rs_valid;
  logic [1:0][31:0] rd;
  logic [1:0]       rd_ready;
  logic [0:0][4:0]  rw;
  logic [0:0]       we;
  logic [0:0][31:0] wval;
  logic             claim;
  logic [4:0]       claim_reg;
  logic [31:0]      busy;

  // Instance B: Width 16, 6 regs, 2 read, 2 write, Bypass 0
  logic [1:0][2:0]  b_rs;
  logic [1:0]       b_rs_valid;
  logic [1:0][15:0] b_rd;
  logic [1:0]       b_rd_ready;
  logic [1:0][2:0]  b_rw;
  logic [1:0]       b_we;
  logic [1:0][15:0] b_wval;
  logic             b_claim;
  logic [2:0]       b_claim_reg;
  logic [5:0]       b_busy;

  regfile_sb u_dut (
    .clk(clk), .reset(reset),
    .rs(rs), .rs_valid(rs_valid), .rd(rd), .rd_ready(rd_ready),
    .rw(rw), .we(we), .wval(wval),
    .claim(claim), .claim_reg(claim_reg), .busy(busy)
  );

  regfile_sb #(.Width(16), .NumRegs(6), .NumRead(2), .NumWrite(2), .Bypass(0)) u_nb (
    .clk(clk), .reset(reset),
    .rs(b_rs), .rs_valid(b_rs_valid), .rd(b_rd), .rd_ready(b_rd_ready),
    .rw(b_rw), .we(b_we), .wval(b_wval),
    .claim(b_claim), .claim_reg(b_claim_reg), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the random sweep on instance A
  logic [31:0] m_regs [32];
  logic        m_busy [32];

  initial begin
    reset = 1'b1;
    rs = '0; rs_valid = '0; rw = '0; we = '0; wval = '0; claim = 1'b0; claim_reg = '0;
    b_rs = '0; b_rs_valid = '0; b_rw = '0; b_we = '0; b_wval = '0;
    b_claim = 1'b0; b_claim_reg = '0;
    tick();
    reset = 1'b0;

    // 1: reset state
    #1;
    chk("reset_busy", busy, 32'h0);
    chk("reset_b_busy", 32'(b_busy), 32'h0);
    rs_valid = 2'b11;
    for (int k = 0; k < 32; k++) begin
      rs[0] = 5'(k);
      rs[1] = 5'(31 - k);
      #1;
      chk($sformatf("reset_rd0_r%0d", k), rd[0], 32'h0);
      chk($sformatf("reset_rdy0_r%0d", k), 32'(rd_ready[0]), 32'h1);
      chk($sformatf("reset_rd1_r%0d", 31 - k), rd[1], 32'h0);
      chk($sformatf("reset_rdy1_r%0d", 31 - k), 32'(rd_ready[1]), 32'h1);
    end

    // 2: write reg 1, read next cycle; write to reg 0 discarded
    we = 1'b1; rw[0] = 5'd1; wval[0] = 32'd123;
    tick();
    we = 1'b0; rs[0] = 5'd1; rs_valid = 2'b01;
    #1;
    chk("w1_rd", rd[0], 32'd123);
    chk("w1_rdy", 32'(rd_ready[0]), 32'h1);
    rs_valid = 2'b00;
    #1;
    chk("w1_rs_invalid_rd", rd[0], 32'h0);
    chk("w1_rs_invalid_rdy", 32'(rd_ready[0]), 32'h1);
    we = 1'b1; rw[0] = 5'd0; wval[0] = 32'd55;
    tick();
    we = 1'b0; rs[0] = 5'd0; rs_valid = 2'b01;
    #1;
    chk("w0_rd", rd[0], 32'h0);
    chk("w0_rdy", 32'(rd_ready[0]), 32'h1);
    chk("w0_busy", busy, 32'h0);

    // 3: claim reg 5, then write it with forwarding
    claim = 1'b1; claim_reg = 5'd5;
    tick();
    claim = 1'b0; rs[1] = 5'd5; rs_valid = 2'b10;
    #1;
    chk("c5_busy", busy, 32'h0000_0020);
    chk("c5_rdy", 32'(rd_ready[1]), 32'h0);
    chk("c5_rd_array", rd[1], 32'h0);
    we = 1'b1; rw[0] = 5'd5; wval[0] = 32'd456;
    #1;
    chk("c5_bypass_rd", rd[1], 32'd456);
    chk("c5_bypass_rdy", 32'(rd_ready[1]), 32'h1);
    tick();
    we = 1'b0;
    #1;
    chk("c5_after_busy", busy, 32'h0);
    chk("c5_after_rd", rd[1], 32'd456);
    chk("c5_after_rdy", 32'(rd_ready[1]), 32'h1);

    // 4: claim and write reg 7 in one cycle -> claim wins
    claim = 1'b1; claim_reg = 5'd7; we = 1'b1; rw[0] = 5'd7; wval[0] = 32'd9;
    tick();
    claim = 1'b0; we = 1'b0; rs[0] = 5'd7; rs_valid = 2'b01;
    #1;
    chk("c7_busy", busy, 32'h0000_0080);
    chk("c7_rd", rd[0], 32'd9);
    chk("c7_rdy", 32'(rd_ready[0]), 32'h0);
    claim = 1'b1; claim_reg = 5'd7;   // re-claim while busy stays busy
    tick();
    claim = 1'b0;
    #1;
    chk("c7_reclaim_rdy", 32'(rd_ready[0]), 32'h0);
    we = 1'b1; rw[0] = 5'd7; wval[0] = 32'd10;
    tick();
    we = 1'b0;
    #1;
    chk("c7_release_busy", busy, 32'h0);
    chk("c7_release_rd", rd[0], 32'd10);
    chk("c7_release_rdy", 32'(rd_ready[0]), 32'h1);
    claim = 1'b1; claim_reg = 5'd0;
    tick();
    claim = 1'b0;
    #1;
    chk("claim0_busy", busy, 32'h0);

    // 5: instance B, two ports write reg 3; no forwarding
    b_we = 2'b11; b_rw[0] = 3'd3; b_rw[1] = 3'd3; b_wval[0] = 16'd10; b_wval[1] = 16'd20;
    b_rs[0] = 3'd3; b_rs_valid = 2'b01;
    #1;
    chk("b_nobypass_rd", 32'(b_rd[0]), 32'h0);
    chk("b_nobypass_rdy", 32'(b_rd_ready[0]), 32'h1);
    tick();
    b_we = 2'b00;
    #1;
    chk("b_dual_write_rd", 32'(b_rd[0]), 32'd20);
    // out-of-range write and claim must disturb nothing
    b_we = 2'b01; b_rw[0] = 3'd6; b_wval[0] = 16'd77;
    b_claim = 1'b1; b_claim_reg = 3'd7;
    tick();
    b_we = 2'b00; b_claim = 1'b0;
    b_rs[1] = 3'd5; b_rs_valid = 2'b11;
    #1;
    chk("b_oob_busy", 32'(b_busy), 32'h0);
    chk("b_oob_r3", 32'(b_rd[0]), 32'd20);
    chk("b_oob_r5", 32'(b_rd[1]), 32'h0);
    // claim reg 5 and write it same cycle on B: busy stays, no forward
    b_claim = 1'b1; b_claim_reg = 3'd5; b_we = 2'b10; b_rw[1] = 3'd5; b_wval[1] = 16'hBEEF;
    tick();
    b_claim = 1'b0; b_we = 2'b00;
    #1;
    chk("b_c5_busy", 32'(b_busy), 32'h20);
    chk("b_c5_rd", 32'(b_rd[1]), 32'hBEEF);
    chk("b_c5_rdy", 32'(b_rd_ready[1]), 32'h0);

    // 6: regs 1,2 hold 123/456, reg 4 busy, then reset with a pending write/claim
    we = 1'b1; rw[0] = 5'd2; wval[0] = 32'd456; claim = 1'b1; claim_reg = 5'd4;
    tick();
    we = 1'b0; claim = 1'b0;
    rs[0] = 5'd2; rs[1] = 5'd4; rs_valid = 2'b11;
    #1;
    chk("pre_rst_r2", rd[0], 32'd456);
    chk("pre_rst_busy", busy, 32'h0000_0010);
    chk("pre_rst_r4_rdy", 32'(rd_ready[1]), 32'h0);
    reset = 1'b1; we = 1'b1; rw[0] = 5'd3; wval[0] = 32'd1; claim = 1'b1; claim_reg = 5'd6;
    tick();
    reset = 1'b0; we = 1'b0; claim = 1'b0;
    #1;
    chk("rst_busy", busy, 32'h0);
    chk("rst_b_busy", 32'(b_busy), 32'h0);
    for (int k = 1; k < 8; k++) begin
      rs[0] = 5'(k);
      #1;
      chk($sformatf("rst_rd_r%0d", k), rd[0], 32'h0);
      chk($sformatf("rst_rdy_r%0d", k), 32'(rd_ready[0]), 32'h1);
    end
    b_rs[0] = 3'd3;
    #1;
    chk("rst_b_r3", 32'(b_rd[0]), 32'h0);

    // Random traffic on instance A against the reference model
    for (int k = 0; k < 32; k++) begin
      m_regs[k] = '0;
      m_busy[k] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      logic [31:0] exp_busy;
      logic [31:0] exp_rd;
      logic        exp_rdy;
      we[0]     = 1'($urandom_range(0, 1));
      rw[0]     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wval[0]   = $urandom;
      claim     = 1'($urandom_range(0, 1));
      claim_reg = 5'($urandom_range(0, 7));
      rs_valid  = 2'($urandom_range(0, 3));
      rs[0]     = 5'($urandom_range(0, 7));
      rs[1]     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      #1;
      for (int j = 0; j < 2; j++) begin
        if (!rs_valid[j] || rs[j] == 5'd0) begin
          exp_rd = '0; exp_rdy = 1'b1;
        end else if (we[0] && rw[0] == rs[j]) begin
          exp_rd = wval[0]; exp_rdy = 1'b1;
        end else begin
          exp_rd = m_regs[rs[j]]; exp_rdy = ~m_busy[rs[j]];
        end
        chk($sformatf("rnd%0d_rd%0d", n, j), rd[j], exp_rd);
        chk($sformatf("rnd%0d_rdy%0d", n, j), 32'(rd_ready[j]), 32'(exp_rdy));
      end
      exp_busy = '0;
      for (int k = 0; k < 32; k++) exp_busy[k] = m_busy[k];
      chk($sformatf("rnd%0d_busy", n), busy, exp_busy);
      if (we[0] && rw[0] != 5'd0) begin
        m_regs[rw[0]] = wval[0];
        m_busy[rw[0]] = 1'b0;
      end
      if (claim && claim_reg != 5'd0) m_busy[claim_reg] = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
